// File: rtl/sram_port_arbiter_pkg.sv
// Shared owner encodings, lane count and request-bundle width for the SRAM port arbiter.
`ifndef SRAM_PORT_ARBITER_PKG_SV
`define SRAM_PORT_ARBITER_PKG_SV

// Packed request bundle {req, wen, addr, wdata}
`define ARB_REQ_W(aw, dw) (1 + 4 + (aw) + (dw))

package sram_port_arbiter_pkg;

   localparam int ARB_LANES = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_RD_I = 2'b01,
      ARB_RD_D = 2'b10
   } arb_owner_e;

endpackage

`endif

// File: rtl/arb_rdata_hold.sv
// Per-requester read-return register: pulses rvalid and passes sram data through on the
// return cycle, then holds it until that requester's next read returns.
module arb_rdata_hold #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_i,
   input  logic [DATA_W-1:0] sram_rdata_i,
   output logic              rvalid_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // NOTE: default assignment first so the hold path never infers a latch.
   always_comb begin
      data_d = data_q;
      if (cap_i) data_d = sram_rdata_i;
   end

   // NOTE: non-blocking in clocked logic; reset is synchronous and clears the held data.
   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   // Gated by rst so the return discarded by a mid-read reset never shows on the outputs.
   assign rvalid_o = cap_i & ~rst;
   assign rdata_o  = rst ? '0 : data_d;

endmodule

// File: rtl/sram_port_arbiter.sv
// Fixed-priority (D over I) arbiter sharing one single-port SRAM between fetch and load/store.
// Build option: ARB_STARVE_GUARD_EN lets I win after STARVE_LIMIT consecutive contended D grants.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_req,
   input  logic [ADDR_W-1:0]    i_addr,
   output logic                 i_gnt,
   output logic                 i_rvalid,
   output logic [DATA_W-1:0]    i_rdata,
   output logic                 i_stall_req,
   input  logic                 d_req,
   input  logic [ARB_LANES-1:0] d_wen,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [DATA_W-1:0]    d_wdata,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [DATA_W-1:0]    d_rdata,
   output logic                 sram_en,
   output logic [ARB_LANES-1:0] sram_wen,
   output logic [ADDR_W-1:0]    sram_addr,
   output logic [DATA_W-1:0]    sram_wdata,
   input  logic [DATA_W-1:0]    sram_rdata
);

   localparam int REQ_W = `ARB_REQ_W(ADDR_W, DATA_W);

   if (DATA_W != 32 || STARVE_LIMIT < 1) begin : g_bad_cfg
      $error("sram_port_arbiter: DATA_W must be 32 and STARVE_LIMIT at least 1");
   end

   arb_owner_e       owner_q;
   logic             d_win;
   logic             i_win;
   logic             force_i;
   logic [REQ_W-1:0] d_bundle;
   logic [REQ_W-1:0] i_bundle;
   logic [REQ_W-1:0] win_bundle;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_q;

   assign force_i = i_req && (starve_q == CNT_W'(STARVE_LIMIT));

   // Saturates at the limit; any I grant restarts the count
   always_ff @(posedge clk) begin
      if (rst || i_win)
         starve_q <= '0;
      else if (d_win && i_req && starve_q != CNT_W'(STARVE_LIMIT))
         starve_q <= starve_q + 1'b1;
   end
`else
   assign force_i = 1'b0;
`endif

   always_comb begin
      d_win = 1'b0;
      i_win = 1'b0;
      if (!rst) begin
         if (d_req && !force_i) d_win = 1'b1;
         else if (i_req)        i_win = 1'b1;
      end
   end

   assign d_bundle   = {d_req, d_wen, d_addr, d_wdata};
   assign i_bundle   = {i_req, {ARB_LANES{1'b0}}, i_addr, {DATA_W{1'b0}}};
   assign win_bundle = d_win ? d_bundle : (i_win ? i_bundle : '0);

   // The winner's req bit lands in sram_en, so it is exactly the OR of the grants
   assign {sram_en, sram_wen, sram_addr, sram_wdata} = win_bundle;

   assign d_gnt       = d_win;
   assign i_gnt       = i_win;
   assign i_stall_req = i_req & ~i_win & ~rst;

   always_ff @(posedge clk) begin
      if (rst)                        owner_q <= ARB_IDLE;
      else if (d_win && d_wen == '0)  owner_q <= ARB_RD_D;
      else if (i_win)                 owner_q <= ARB_RD_I;
      else                            owner_q <= ARB_IDLE;
   end

   arb_rdata_hold #(.DATA_W(DATA_W)) u_hold_i (
      .clk          (clk),
      .rst          (rst),
      .cap_i        (owner_q == ARB_RD_I),
      .sram_rdata_i (sram_rdata),
      .rvalid_o     (i_rvalid),
      .rdata_o      (i_rdata)
   );

   arb_rdata_hold #(.DATA_W(DATA_W)) u_hold_d (
      .clk          (clk),
      .rst          (rst),
      .cap_i        (owner_q == ARB_RD_D),
      .sram_rdata_i (sram_rdata),
      .rvalid_o     (d_rvalid),
      .rdata_o      (d_rdata)
   );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a pending-return reference model.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt, i_rvalid, i_stall_req;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic [3:0]  d_wen = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = '0;

   int tests = 0;
   int fails = 0;

   sram_port_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_gnt       (i_gnt),
      .i_rvalid    (i_rvalid),
      .i_rdata     (i_rdata),
      .i_stall_req (i_stall_req),
      .d_req       (d_req),
      .d_wen       (d_wen),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_gnt       (d_gnt),
      .d_rvalid    (d_rvalid),
      .d_rdata     (d_rdata),
      .sram_en     (sram_en),
      .sram_wen    (sram_wen),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: which requester (0 none, 1 I, 2 D) is owed a read return next cycle,
   // and the last data each requester received.
   int          pend = 0;
   logic [31:0] hold_i = '0;
   logic [31:0] hold_d = '0;
   logic        e_dg, e_ig;
   logic [31:0] e_irdata, e_drdata;

   always @(negedge clk) begin
      if (rst) begin
         e_dg = 1'b0; e_ig = 1'b0;
         check("m_rst_gnt",   {i_gnt, d_gnt, i_stall_req}, '0);
         check("m_rst_rv",    {i_rvalid, d_rvalid}, '0);
         check("m_rst_rdata", {i_rdata, d_rdata}, '0);
         check("m_rst_sram",  {sram_en, sram_wen, sram_addr, sram_wdata}, '0);
         pend = 0; hold_i = '0; hold_d = '0;
      end else begin
         e_dg = d_req;
         e_ig = i_req & ~d_req;
         e_irdata = (pend == 1) ? sram_rdata : hold_i;
         e_drdata = (pend == 2) ? sram_rdata : hold_d;
         check("m_gnt",     {i_gnt, d_gnt}, {e_ig, e_dg});
         check("m_stall",   i_stall_req, i_req & ~e_ig);
         check("m_sram_en", sram_en, e_dg | e_ig);
         check("m_sram_addr", sram_addr, e_dg ? d_addr : (e_ig ? i_addr : 32'h0));
         check("m_sram_wen",  sram_wen, e_dg ? d_wen : 4'h0);
         check("m_sram_wdata", sram_wdata, e_dg ? d_wdata : 32'h0);
         check("m_rvalid",  {i_rvalid, d_rvalid}, {pend == 1, pend == 2});
         check("m_i_rdata", i_rdata, e_irdata);
         check("m_d_rdata", d_rdata, e_drdata);
         hold_i = e_irdata;
         hold_d = e_drdata;
         pend = (e_dg && d_wen == 4'h0) ? 2 : (e_ig ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   logic seen_ig, seen_dg;

   initial begin
      // Reset
      tick(); tick();
      settle();
      check("rst_outputs", {i_gnt, d_gnt, i_rvalid, d_rvalid, sram_en, i_stall_req}, '0);
      tick(); rst = 1'b0;

      // I read at 0x1000, data returned next cycle and held
      tick(); i_req = 1'b1; i_addr = 32'h1000;
      settle();
      check("t1_i_gnt", i_gnt, 1'b1);
      check("t1_en_wen", {sram_en, sram_wen}, {1'b1, 4'h0});
      check("t1_addr", sram_addr, 32'h1000);
      tick(); i_req = 1'b0; sram_rdata = 32'hDEADBEEF;
      settle();
      check("t1_rvalid", i_rvalid, 1'b1);
      check("t1_rdata", i_rdata, 32'hDEADBEEF);
      for (int c = 2; c <= 5; c++) begin
         tick(); sram_rdata = $urandom;
      end
      settle();
      check("t1_hold_c5", {i_rvalid, i_rdata}, {1'b0, 32'hDEADBEEF});

      // Contention: D wins, I stalls then wins next cycle
      tick(); d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h2004; i_req = 1'b1; i_addr = 32'h40;
      settle();
      check("t2_gnts", {d_gnt, i_gnt, i_stall_req}, 3'b101);
      check("t2_addr", sram_addr, 32'h2004);
      tick(); d_req = 1'b0; sram_rdata = 32'h11112222;
      settle();
      check("t2_i_gnt", {i_gnt, i_stall_req}, 2'b10);
      check("t2_d_ret", {d_rvalid, d_rdata}, {1'b1, 32'h11112222});
      tick(); i_req = 1'b0; sram_rdata = 32'h33334444;
      settle();
      check("t2_i_ret", {i_rvalid, i_rdata}, {1'b1, 32'h33334444});

      // Byte-lane store: no read return follows
      tick(); d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h3000; d_wdata = 32'h0000ABCD;
      settle();
      check("t3_store", {sram_en, sram_wen, sram_addr, sram_wdata},
            {1'b1, 4'b0011, 32'h3000, 32'h0000ABCD});
      tick(); d_req = 1'b0; d_wen = 4'h0; sram_rdata = 32'h99999999;
      settle();
      check("t3_no_rvalid", {d_rvalid, d_rdata}, {1'b0, 32'h11112222});

      // Alternating I/D reads at full rate
      for (int k = 0; k < 5; k++) begin
         tick();
         i_req = (k < 4) && (k % 2 == 0); i_addr = 32'h10;
         d_req = (k < 4) && (k % 2 == 1); d_addr = 32'h20;
         sram_rdata = 32'hA0 + k;
         settle();
         if (k < 4) check("t4_one_gnt", {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k > 0) begin
            check("t4_rvalid", {i_rvalid, d_rvalid}, (k % 2 == 1) ? 2'b10 : 2'b01);
            check("t4_rdata", (k % 2 == 1) ? i_rdata : d_rdata, 32'hA0 + k);
         end
      end

      // Reset right after a D read grant
      tick(); d_req = 1'b1; d_addr = 32'h20;
      settle();
      check("t5_d_gnt", d_gnt, 1'b1);
      tick(); rst = 1'b1; d_req = 1'b0; sram_rdata = 32'h5555AAAA;
      settle();
      check("t5_rst_ret", {d_rvalid, d_rdata}, {1'b0, 32'h0});
      check("t5_rst_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, '0);
      tick(); rst = 1'b0;
      settle();
      check("t5_after_rst", {d_rvalid, d_rdata, i_rdata}, {1'b0, 64'h0});

      // Randomized traffic; requests are held until granted
      for (int c = 0; c < 3000; c++) begin
         settle();
         seen_ig = i_gnt; seen_dg = d_gnt;
         tick();
         if (!i_req || seen_ig) begin
            i_req  = ($urandom_range(0, 99) < 60);
            i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req || seen_dg) begin
            d_req   = ($urandom_range(0, 99) < 50);
            d_addr  = $urandom;
            d_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            d_wdata = $urandom;
         end
         sram_rdata = $urandom;
         rst = ($urandom_range(0, 199) == 0);
      end

      tick(); rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
      settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
